// File: rtl/burst_mem_pkg.sv
//------------------------------------------------------------------------------
// Module      : burst_mem_pkg
// Description : State encoding and width helper shared by the burst memory.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package burst_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_BURST = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Bits needed to count 0..value-1, never less than one so counters stay legal.
   function automatic int clog2_min1(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) begin
         w++;
      end
      return w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/burst_mem_if.sv
//------------------------------------------------------------------------------
// Module      : burst_mem_if
// Description : Burst request/transfer bus between cache controller and memory.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface burst_mem_if #(
   parameter int ADR_WIDTH  = 8,
   parameter int DATA_WIDTH = 16
);
   logic                  req;
   logic                  wr;
   logic [ADR_WIDTH-1:0]  address;
   logic [DATA_WIDTH-1:0] datain;
   logic [DATA_WIDTH-1:0] dataout;
   logic                  busy;
   logic                  beat;
   logic                  done;

   modport master (
      output req, wr, address, datain,
      input  dataout, busy, beat, done
   );

   modport slave (
      input  req, wr, address, datain,
      output dataout, busy, beat, done
   );
endinterface

`default_nettype wire

// File: rtl/burst_mem_mem_array.sv
//------------------------------------------------------------------------------
// Module      : mem_array
// Description : Single-port storage, synchronous write and combinational read.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_array #(
   parameter int ADR_WIDTH  = 8,
   parameter int DATA_WIDTH = 16,
   parameter int MEM_SIZE   = 1 << ADR_WIDTH
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADR_WIDTH-1:0]  addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

`default_nettype wire

// File: rtl/burst_mem.sv
//------------------------------------------------------------------------------
// Module      : burst_mem
// Description : Line-oriented burst memory with programmable wait states.
//               MEM_CRITICAL_WORD_FIRST_EN starts the burst at the requested word.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module burst_mem
   import burst_mem_pkg::*;
#(
   parameter int ADR_WIDTH   = 8,
   parameter int DATA_WIDTH  = 16,
   parameter int LINE_WORDS  = 4,
   parameter int WAIT_CYCLES = 2,
   parameter int MEM_SIZE    = 1 << ADR_WIDTH
) (
   input  logic        clk,
   input  logic        rst,
   burst_mem_if.slave  bus
);

   localparam int OFS_W  = clog2_min1(LINE_WORDS);
   localparam int WAIT_W = clog2_min1(WAIT_CYCLES);
   localparam logic [OFS_W-1:0]     LAST_BEAT = OFS_W'(LINE_WORDS - 1);
   localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam logic [ADR_WIDTH-1:0] LINE_MASK = ADR_WIDTH'(LINE_WORDS - 1);

   state_t                state;
   state_t                state_nxt;
   logic                  wr_q;
   logic [ADR_WIDTH-1:0]  base;
   logic [OFS_W-1:0]      offset;
   logic [OFS_W-1:0]      beat_cnt;
   logic [WAIT_W-1:0]     wait_cnt;
   logic [OFS_W-1:0]      start_ofs;
   logic [ADR_WIDTH-1:0]  word_addr;
   logic                  we;
   logic [DATA_WIDTH-1:0] rdata;

`ifdef MEM_CRITICAL_WORD_FIRST_EN
   assign start_ofs = bus.address[OFS_W-1:0];
`else
   assign start_ofs = '0;
`endif

   // Offset only ever occupies the cleared low bits, so the line never carries into base.
   assign word_addr = base | {{(ADR_WIDTH-OFS_W){1'b0}}, offset};
   assign we        = (state == ST_BURST) && wr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      bus.busy    = 1'b1;
      bus.beat    = 1'b0;
      bus.done    = 1'b0;
      bus.dataout = '0;
      case (state)
         ST_IDLE: begin
            bus.busy = 1'b0;
            if (bus.req) begin
               state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_BURST;
            end
         end
         ST_WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
               state_nxt = ST_BURST;
            end
         end
         ST_BURST: begin
            bus.beat = 1'b1;
            if (!wr_q) begin
               bus.dataout = rdata;
            end
            if (beat_cnt == LAST_BEAT) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            bus.done  = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q     <= 1'b0;
         base     <= '0;
         offset   <= '0;
         beat_cnt <= '0;
         wait_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req) begin
                  wr_q     <= bus.wr;
                  base     <= bus.address & ~LINE_MASK;
                  offset   <= start_ofs;
                  beat_cnt <= '0;
                  wait_cnt <= '0;
               end
            end
            ST_WAIT: begin
               wait_cnt <= wait_cnt + 1'b1;
            end
            ST_BURST: begin
               offset   <= offset + 1'b1;
               beat_cnt <= beat_cnt + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   mem_array #(
      .ADR_WIDTH  (ADR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_SIZE   (MEM_SIZE)
   ) u_mem_array (
      .clk   (clk),
      .we    (we),
      .addr  (word_addr),
      .wdata (bus.datain),
      .rdata (rdata)
   );

endmodule

`default_nettype wire
